prbs_lfsr_gen: RTL and testbench
================================

Name: prbs_lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random sequence generator. It replaces the fixed 7-bit all-ones-seeded shift chain.
- Adds:
  - configurable width and tap mask
  - step enable
  - runtime seed load
  - all-zero lock-up recovery
  - wrap detection with measured period
- Sits in the binary-sequence test block set. It feeds pattern sources and BIST paths.
- An optional self-synchronising checker (macro-controlled) verifies a received stream against the same polynomial.

Parameters:
- N, 7: LFSR length in bits (≥3).
- TAP_MASK, 7'h41: feedback mask. fb = XOR of s[i] where TAP_MASK[i]=1. The default reproduces x^7+x^6+1, period 127.
- SYNC_LEN, 16: consecutive matching bits the checker needs to declare lock.
- LOSS_LEN, 8: consecutive mismatching bits after which the checker drops lock.
- ERR_W, 16: checker error counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance LFSR one step this cycle
- load  in  1  load seed this cycle
- seed  in  N  seed value for load
- q  out  N  current LFSR state (registered)
- bit_out  out  1  serial output, equal to q[N-1]
- lockup  out  1  one-cycle pulse: zero state was substituted
- wrap  out  1  one-cycle pulse: state returned to start value
- period  out  N  step count of the last completed cycle
- chk_in  in  1  received bit (PRBS_CHECK_EN only)
- chk_valid  in  1  chk_in qualifier (PRBS_CHECK_EN only)
- chk_lock  out  1  checker locked (PRBS_CHECK_EN only)
- err_cnt  out  ERR_W  saturating bit-error count (PRBS_CHECK_EN only)

Behaviour:
- Reset, synchronous at the clk edge with rst=1:
  - q = all ones; start register = all ones
  - step count = 0; period = 0
  - lockup = 0; wrap = 0
- Priority is rst > load > en. With none asserted, q holds and the pulse outputs are 0.
- Step (en=1): fb = ^(q & TAP_MASK); next = {q[N-2:0], fb}. Result visible one cycle after the en edge.
- Load (load=1):
  - q = seed and start = seed; step count = 0; wrap = 0.
  - If seed == 0: load all ones instead, set start = all ones, and pulse lockup.
- Lock-up guard: if a step's next value is 0 (possible with a non-primitive mask), load all ones instead and pulse lockup. start and the step count are unchanged.
- Wrap:
  - Each step increments the step count (N-bit, wraps modulo 2^N).
  - When next == start: pulse wrap in the cycle q becomes start, latch period = count+1, and clear the count.
  - Default mask from reset gives wrap and period = 127 on the 127th step.
- load and en together: load wins and no step occurs.
- A load asserted with rst is ignored.

Optional Feature:
- PRBS_CHECK_EN defined adds the checker:
  - Local N-bit register r shifts {r[N-2:0], chk_in} on each chk_valid. Predicted bit p = ^(r & TAP_MASK), compared with chk_in before shifting.
  - FSM has two states, UNLOCK and LOCKED. Reset puts it in UNLOCK with r = 0 and err_cnt = 0.
  - UNLOCK: match counter increments on match and clears on mismatch. At SYNC_LEN it moves to LOCKED and asserts chk_lock.
  - LOCKED: each mismatch increments err_cnt, saturating at all ones. After LOSS_LEN consecutive mismatches it moves to UNLOCK and deasserts chk_lock. err_cnt is kept.
  - chk_valid=0 changes nothing.
- PRBS_CHECK_EN undefined: the checker ports are absent, and generator behaviour is identical.

Decomposition:
- Shared package prbs_pkg holds:
  - default tap-mask constants for common polynomials (PRBS7 7'h41, PRBS9 9'h110, PRBS15 15'h6000, PRBS23, PRBS31)
  - checker state enum {UNLOCK, LOCKED}
- One natural sub-module, prbs_lfsr_step: purely combinational next-state and feedback logic. Both the generator and the checker instantiate it.

Test Plan:
- Reset, then en=1 for 2 cycles -> q = 7'h7F, then 7'h7E, then 7'h7D. bit_out = 1, 1, 1.
- From reset, hold en=1 for 127 cycles -> wrap pulses exactly once, on the 127th step, with q = 7'h7F and period = 127. No repeat of any state earlier.
- load=1, seed=0 -> q = 7'h7F and lockup pulses once. load=1, seed=7'h15 with en=1 in the same cycle -> q = 7'h15 and no step.
- en=0 for 10 cycles mid-sequence -> q unchanged and wrap/lockup stay 0. rst mid-sequence -> q = 7'h7F and period = 0 on the next cycle.
- Checker: feed bit_out into chk_in with chk_valid=1 -> chk_lock rises after 16 valid bits and err_cnt = 0.
  - Invert one bit -> err_cnt = 3 (original bit plus taps 0 and 6) and chk_lock stays 1.
  - Force chk_in = ~bit_out for 8 bits -> chk_lock = 0.
- Stress with N=15, TAP_MASK=15'h6000 for 32767 steps -> period = 32767 and exactly one wrap.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS generator/checker: common tap masks and checker state.
package prbs_pkg;

  localparam logic [6:0]  PRBS7  = 7'h41;
  localparam logic [8:0]  PRBS9  = 9'h110;
  localparam logic [14:0] PRBS15 = 15'h6000;
  localparam logic [22:0] PRBS23 = 23'h420000;
  localparam logic [30:0] PRBS31 = 31'h48000000;

  typedef enum logic {UNLOCK, LOCKED} chk_state_t;

  // Bits needed for a run counter that must reach the larger of two thresholds.
  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/prbs_lfsr_gen_if.sv
// Control/status bundle of the PRBS generator; checker signals exist only with PRBS_CHECK_EN.
interface prbs_lfsr_gen_if #(
  parameter int N = 7
`ifdef PRBS_CHECK_EN
  , parameter int ERR_W = 16
`endif
);
  logic         en;
  logic         load;
  logic [N-1:0] seed;
  logic [N-1:0] q;
  logic         bit_out;
  logic         lockup;
  logic         wrap;
  logic [N-1:0] period;
`ifdef PRBS_CHECK_EN
  logic             chk_in;
  logic             chk_valid;
  logic             chk_lock;
  logic [ERR_W-1:0] err_cnt;

  modport master (output en, load, seed, chk_in, chk_valid,
                  input  q, bit_out, lockup, wrap, period, chk_lock, err_cnt);
  modport slave  (input  en, load, seed, chk_in, chk_valid,
                  output q, bit_out, lockup, wrap, period, chk_lock, err_cnt);
`else
  modport master (output en, load, seed,
                  input  q, bit_out, lockup, wrap, period);
  modport slave  (input  en, load, seed,
                  output q, bit_out, lockup, wrap, period);
`endif
endinterface

// File: rtl/prbs_lfsr_step.sv
// One Fibonacci LFSR step: feedback bit and shifted next state.
// Purely combinational; no backpressure.
module prbs_lfsr_step #(
  parameter int           N        = 7,
  parameter logic [N-1:0] TAP_MASK = 7'h41
) (
  input  logic [N-1:0] cur,
  output logic         fb,
  output logic [N-1:0] nxt
);

  assign fb  = ^(cur & TAP_MASK);
  assign nxt = {cur[N-2:0], fb};

endmodule

// File: rtl/prbs_lfsr_gen.sv
// Parametrised PRBS generator with seed load, lock-up recovery and period measurement;
// PRBS_CHECK_EN adds a self-synchronising checker. State updates one cycle after en/load.
// No backpressure: en is a step strobe, chk_valid qualifies each received bit.
module prbs_lfsr_gen
  import prbs_pkg::*;
#(
  parameter int           N        = 7,
  parameter logic [N-1:0] TAP_MASK = N'(PRBS7)
`ifdef PRBS_CHECK_EN
  , parameter int SYNC_LEN = 16
  , parameter int LOSS_LEN = 8
  , parameter int ERR_W    = 16
`endif
) (
  input logic           clk,
  input logic           rst,
  prbs_lfsr_gen_if.slave bus
);

  localparam logic [N-1:0] ONES = '1;

  logic [N-1:0] q, start, cnt, period;
  logic [N-1:0] nxt, nxt_eff;
  logic         fb, zero_nxt, lockup, wrap;

  prbs_lfsr_step #(.N(N), .TAP_MASK(TAP_MASK)) u_step (
    .cur (q),
    .fb  (fb),
    .nxt (nxt)
  );

  // The shifted state is zero only when the retained bits and the feedback are all zero.
  assign zero_nxt = (q[N-2:0] == '0) && !fb;
  assign nxt_eff  = zero_nxt ? ONES : nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= ONES;
      start  <= ONES;
      cnt    <= '0;
      period <= '0;
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end else if (bus.load) begin
      q      <= (bus.seed == '0) ? ONES : bus.seed;
      start  <= (bus.seed == '0) ? ONES : bus.seed;
      cnt    <= '0;
      lockup <= (bus.seed == '0);
      wrap   <= 1'b0;
    end else if (bus.en) begin
      q      <= nxt_eff;
      lockup <= zero_nxt;
      if (nxt_eff == start) begin
        wrap   <= 1'b1;
        period <= cnt + 1'b1;
        cnt    <= '0;
      end else begin
        wrap   <= 1'b0;
        cnt    <= cnt + 1'b1;
      end
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end
  end

  assign bus.q       = q;
  assign bus.bit_out = q[N-1];
  assign bus.lockup  = lockup;
  assign bus.wrap    = wrap;
  assign bus.period  = period;

`ifdef PRBS_CHECK_EN
  localparam int CW = cnt_w(SYNC_LEN, LOSS_LEN);

  chk_state_t       st, st_nxt;
  logic [N-1:0]     r, r_step, r_nxt;
  logic             p, miss;
  logic [CW-1:0]    mc, mc_nxt;
  logic [ERR_W-1:0] err, err_nxt;

  prbs_lfsr_step #(.N(N), .TAP_MASK(TAP_MASK)) u_chk_step (
    .cur (r),
    .fb  (p),
    .nxt (r_step)
  );

  assign miss  = p ^ bus.chk_in;
  // r_step carries the prediction in bit 0; flipping it on a miss yields the received bit.
  assign r_nxt = r_step ^ {{(N-1){1'b0}}, miss};

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= UNLOCK;
      r   <= '0;
      mc  <= '0;
      err <= '0;
    end else begin
      st  <= st_nxt;
      mc  <= mc_nxt;
      err <= err_nxt;
      if (bus.chk_valid) r <= r_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    mc_nxt  = mc;
    err_nxt = err;
    if (bus.chk_valid) begin
      case (st)
        UNLOCK: begin
          if (miss) begin
            mc_nxt = '0;
          end else if (mc == CW'(SYNC_LEN - 1)) begin
            st_nxt = LOCKED;
            mc_nxt = '0;
          end else begin
            mc_nxt = mc + 1'b1;
          end
        end
        LOCKED: begin
          if (miss) begin
            if (err != '1) err_nxt = err + 1'b1;
            if (mc == CW'(LOSS_LEN - 1)) begin
              st_nxt = UNLOCK;
              mc_nxt = '0;
            end else begin
              mc_nxt = mc + 1'b1;
            end
          end else begin
            mc_nxt = '0;
          end
        end
        default: st_nxt = UNLOCK;
      endcase
    end
  end

  assign bus.chk_lock = (st == LOCKED);
  assign bus.err_cnt  = err;
`endif

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Directed bench for prbs_lfsr_gen: default PRBS7, a non-primitive mask for lock-up, and PRBS15.
module tb_prbs_lfsr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_lfsr_gen_if #(.N(7))  bus ();
  prbs_lfsr_gen_if #(.N(7))  bus_lk ();
  prbs_lfsr_gen_if #(.N(15)) bus15 ();

  prbs_lfsr_gen #(.N(7),  .TAP_MASK(7'h41))    dut    (.clk(clk), .rst(rst), .bus(bus));
  prbs_lfsr_gen #(.N(7),  .TAP_MASK(7'h03))    dut_lk (.clk(clk), .rst(rst), .bus(bus_lk));
  prbs_lfsr_gen #(.N(15), .TAP_MASK(15'h6000)) dut15  (.clk(clk), .rst(rst), .bus(bus15));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit          seen [128];
  int          wraps, wrap_at, repeats, bad, locked_at, wraps15;
  logic [6:0]  q_at_wrap;

  initial begin
    rst = 1'b1;
    bus.en = 0;    bus.load = 0;    bus.seed = '0;
    bus_lk.en = 0; bus_lk.load = 0; bus_lk.seed = '0;
    bus15.en = 0;  bus15.load = 0;  bus15.seed = '0;
`ifdef PRBS_CHECK_EN
    bus.chk_in = 0;    bus.chk_valid = 0;
    bus_lk.chk_in = 0; bus_lk.chk_valid = 0;
    bus15.chk_in = 0;  bus15.chk_valid = 0;
`endif
    tick(); tick();
    rst = 1'b0;

    chk("rst_q",      bus.q,       32'h7F);
    chk("rst_period", bus.period,  32'h0);
    chk("rst_lockup", bus.lockup,  32'h0);
    chk("rst_wrap",   bus.wrap,    32'h0);
    chk("rst_bit",    bus.bit_out, 32'h1);

    bus.en = 1;
    tick();
    chk("step1_q",   bus.q,       32'h7E);
    chk("step1_bit", bus.bit_out, 32'h1);
    tick();
    chk("step2_q",   bus.q,       32'h7D);
    chk("step2_bit", bus.bit_out, 32'h1);
    bus.en = 0;

    // Full period from the reset state.
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    seen[7'h7F] = 1'b1;
    wraps = 0; wrap_at = 0; repeats = 0; q_at_wrap = '0;
    bus.en = 1;
    for (int i = 1; i <= 127; i++) begin
      tick();
      if (bus.wrap) begin
        wraps++;
        wrap_at   = i;
        q_at_wrap = bus.q;
      end
      if (i < 127) begin
        if (seen[bus.q]) repeats++;
        seen[bus.q] = 1'b1;
      end
    end
    bus.en = 0;
    chk("wrap_count",  wraps,      32'd1);
    chk("wrap_step",   wrap_at,    32'd127);
    chk("wrap_q",      q_at_wrap,  32'h7F);
    chk("period_127",  bus.period, 32'd127);
    chk("no_repeat",   repeats,    32'd0);
    tick();
    chk("wrap_clears", bus.wrap,   32'h0);

    // Five steps from 7F -> 7E,7D,7A,75,6A, then hold.
    bus.en = 1;
    repeat (5) tick();
    bus.en = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.q !== 7'h6A || bus.wrap !== 1'b0 || bus.lockup !== 1'b0) bad++;
    end
    chk("hold_q",      bus.q, 32'h6A);
    chk("hold_steady", bad,   32'd0);

    bus.load = 1; bus.seed = 7'h00;
    tick();
    chk("load0_q",      bus.q,      32'h7F);
    chk("load0_lockup", bus.lockup, 32'h1);
    chk("load0_wrap",   bus.wrap,   32'h0);
    bus.load = 0;
    tick();
    chk("load0_pulse",  bus.lockup, 32'h0);

    bus.load = 1; bus.seed = 7'h15; bus.en = 1;
    tick();
    chk("load_en_q",      bus.q,      32'h15);
    chk("load_en_lockup", bus.lockup, 32'h0);
    bus.load = 0; bus.en = 0;
    tick();
    chk("load_hold_q",    bus.q,      32'h15);
    chk("load_keeps_per", bus.period, 32'd127);
    bus.en = 1;
    tick();
    chk("step_after_load", bus.q, 32'h2B);
    bus.en = 0;

    // Mask 7'h03 lacks the top tap, so 7'h40 steps to zero.
    bus_lk.load = 1; bus_lk.seed = 7'h40;
    tick();
    bus_lk.load = 0; bus_lk.en = 1;
    tick();
    chk("guard_q",      bus_lk.q,      32'h7F);
    chk("guard_lockup", bus_lk.lockup, 32'h1);
    chk("guard_wrap",   bus_lk.wrap,   32'h0);
    bus_lk.en = 0;
    tick();
    chk("guard_pulse",  bus_lk.lockup, 32'h0);

    bus.en = 1;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_q",      bus.q,      32'h7F);
    chk("midrst_period", bus.period, 32'h0);
    bus.en = 0;

`ifdef PRBS_CHECK_EN
    rst = 1; tick(); rst = 0;
    chk("chk_rst_lock", bus.chk_lock, 32'h0);
    chk("chk_rst_err",  bus.err_cnt,  32'h0);
    bus.en = 1; bus.chk_valid = 1;
    locked_at = -1;
    for (int i = 0; i < 60; i++) begin
      bus.chk_in = bus.bit_out;
      tick();
      if (bus.chk_lock && locked_at < 0) locked_at = i;
    end
    chk("chk_lock",       bus.chk_lock,       32'h1);
    chk("chk_lock_late",  (locked_at >= 15),  32'h1);
    chk("chk_err0",       bus.err_cnt,        32'h0);

    bus.chk_in = ~bus.bit_out;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.chk_in = bus.bit_out;
      tick();
    end
    chk("chk_err3",  bus.err_cnt,  32'd3);
    chk("chk_keep",  bus.chk_lock, 32'h1);

    // Inverting the stream gives one miss, six matches, then misses once both taps are inverted.
    for (int i = 0; i < 14; i++) begin
      bus.chk_in = ~bus.bit_out;
      tick();
    end
    chk("chk_loss_edge", bus.chk_lock, 32'h1);
    bus.chk_in = ~bus.bit_out;
    tick();
    chk("chk_loss",      bus.chk_lock, 32'h0);
    chk("chk_err_kept",  bus.err_cnt,  32'd12);
    bus.en = 0; bus.chk_valid = 0;
`endif

    rst = 1; tick(); rst = 0;
    wraps15 = 0;
    bus15.en = 1;
    for (int i = 1; i <= 32767; i++) begin
      tick();
      if (bus15.wrap) wraps15++;
    end
    bus15.en = 0;
    chk("p15_wraps",  wraps15,      32'd1);
    chk("p15_period", bus15.period, 32'd32767);
    chk("p15_q",      bus15.q,      32'h7FFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
